// File: rtl/wb_queue_x2.sv
// wb_queue_x2: write-back collector for the register-file write port.
//
// Collects results from two producers (p0: single-cycle ALU, p1: long-latency unit).
// Results go into an in-order FIFO. At most one result retires into the register file
// per cycle.
//
// When the same cycle carries results from both producers, p0 is ordered ahead of p1.
// Readies come only from the registered occupancy, so they never depend on the valids
// in the same cycle.
//
// Optional feature: define WB_BYPASS_EN to let a transferring result skip the empty FIFO
// and go straight into the output registers (latency 1 instead of 2).
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   p0_valid_i/rd_i/data_i     producer 0 result; p0_ready_o when there is room for one entry
//   p1_valid_i/rd_i/data_i     producer 1 result; p1_ready_o when there is room for two entries
//   wb_o, wb_r_o, result_o     write-back strobe, register index, data
//   count_o, empty_o           FIFO occupancy and empty flag
module wb_queue_x2 #(
    parameter int unsigned W_RD  = 4,
    parameter int unsigned W_OPR = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       p0_valid_i,
    input  logic [W_RD-1:0]            p0_rd_i,
    input  logic [W_OPR-1:0]           p0_data_i,
    output logic                       p0_ready_o,
    input  logic                       p1_valid_i,
    input  logic [W_RD-1:0]            p1_rd_i,
    input  logic [W_OPR-1:0]           p1_data_i,
    output logic                       p1_ready_o,
    output logic                       wb_o,
    output logic [W_RD-1:0]            wb_r_o,
    output logic [W_OPR-1:0]           result_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W_RD-1:0]  r_rd_mem   [DEPTH];
    logic [W_OPR-1:0] r_data_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_wb;
    logic [W_RD-1:0]  r_wb_r;
    logic [W_OPR-1:0] r_result;

    logic [CW-1:0]    w_free;
    logic             w_p0_xfer;
    logic             w_p1_xfer;
    logic             w_deq;
    logic             w_byp_p0;
    logic             w_byp_p1;
    logic             w_enq0;
    logic             w_enq1;
    logic [AW-1:0]    w_p1_slot;
    logic [CW-1:0]    w_enq_n;

    always_comb begin
        w_free     = CW'(DEPTH) - r_count;
        p0_ready_o = ~reset & (w_free >= CW'(1));
        p1_ready_o = ~reset & (w_free >= CW'(2));
        w_p0_xfer  = p0_valid_i & p0_ready_o;
        w_p1_xfer  = p1_valid_i & p1_ready_o;
        w_deq      = (r_count != '0);
`ifdef WB_BYPASS_EN
        // Only an empty FIFO can be bypassed, so bypass and dequeue are mutually exclusive.
        w_byp_p0   = (r_count == '0) & w_p0_xfer;
        w_byp_p1   = (r_count == '0) & ~w_p0_xfer & w_p1_xfer;
`else
        w_byp_p0   = 1'b0;
        w_byp_p1   = 1'b0;
`endif
        w_enq0     = w_p0_xfer & ~w_byp_p0;
        w_enq1     = w_p1_xfer & ~w_byp_p1;
        // p1 lands behind p0 when both enqueue in the same cycle.
        w_p1_slot  = r_wr_ptr + AW'(w_enq0);
        w_enq_n    = CW'(w_enq0) + CW'(w_enq1);
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_enq0) begin
                r_rd_mem[r_wr_ptr]   <= p0_rd_i;
                r_data_mem[r_wr_ptr] <= p0_data_i;
            end
            if (w_enq1) begin
                r_rd_mem[w_p1_slot]   <= p1_rd_i;
                r_data_mem[w_p1_slot] <= p1_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_wb     <= 1'b0;
            r_wb_r   <= '0;
            r_result <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_enq_n);
            r_count  <= r_count + w_enq_n - CW'(w_deq);
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_wb     <= 1'b1;
                r_wb_r   <= r_rd_mem[r_rd_ptr];
                r_result <= r_data_mem[r_rd_ptr];
            end else if (w_byp_p0) begin
                r_wb     <= 1'b1;
                r_wb_r   <= p0_rd_i;
                r_result <= p0_data_i;
            end else if (w_byp_p1) begin
                r_wb     <= 1'b1;
                r_wb_r   <= p1_rd_i;
                r_result <= p1_data_i;
            end else begin
                r_wb     <= 1'b0;
            end
        end
    end

    assign wb_o     = r_wb;
    assign wb_r_o   = r_wb_r;
    assign result_o = r_result;
    assign count_o  = r_count;
    assign empty_o  = (r_count == '0);

endmodule
